// File: rtl/layer_seq_pkg.sv
// Shared encodings for the layer sequencer: FSM states, control-word command
// codes, ctrl0 field positions and small phase-ordering helpers.
package layer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WEIGHT = 3'd2,
    ST_BIAS   = 3'd3,
    ST_RUN    = 3'd4,
    ST_GAP    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } seq_state_e;

  localparam logic [1:0] CMD_IDLE   = 2'b00;
  localparam logic [1:0] CMD_WEIGHT = 2'b01;
  localparam logic [1:0] CMD_BIAS   = 2'b10;
  localparam logic [1:0] CMD_RUN    = 2'b11;

  localparam int CMD_LSB    = 0;
  localparam int SKIP_W_BIT = 2;
  localparam int SKIP_B_BIT = 3;

  // Phases run WEIGHT, BIAS, RUN; prev = ST_FETCH asks for the first phase of a layer.
  function automatic seq_state_e next_phase(input seq_state_e prev, input logic skip_w,
                                            input logic skip_b);
    seq_state_e nxt;
    case (prev)
      ST_FETCH: begin
        if (!skip_w)      nxt = ST_WEIGHT;
        else if (!skip_b) nxt = ST_BIAS;
        else              nxt = ST_RUN;
      end
      ST_WEIGHT: begin
        if (!skip_b) nxt = ST_BIAS;
        else         nxt = ST_RUN;
      end
      default: nxt = ST_RUN;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] phase_cmd(input seq_state_e st);
    logic [1:0] cmd;
    case (st)
      ST_WEIGHT: cmd = CMD_WEIGHT;
      ST_BIAS:   cmd = CMD_BIAS;
      ST_RUN:    cmd = CMD_RUN;
      default:   cmd = CMD_IDLE;
    endcase
    return cmd;
  endfunction

  function automatic logic [31:0] with_cmd(input logic [31:0] word, input logic [1:0] cmd);
    logic [31:0] w;
    w = word;
    w[CMD_LSB +: 2] = cmd;
    return w;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control channel between the layer sequencer and control_unit: three control
// words out, three one-cycle finish pulses back.
interface layer_sequencer_if;
  logic [31:0] axi_control_0;
  logic [31:0] axi_control_1;
  logic [31:0] axi_control_2;
  logic        write_weight_finish;
  logic        write_bias_finish;
  logic        layer_finish;

  modport master (
    output axi_control_0, axi_control_1, axi_control_2,
    input  write_weight_finish, write_bias_finish, layer_finish
  );

  modport slave (
    input  axi_control_0, axi_control_1, axi_control_2,
    output write_weight_finish, write_bias_finish, layer_finish
  );
endinterface

// File: rtl/layer_sequencer_desc_ram.sv
// Per-layer descriptor table: three 32-bit words per entry, word-granular
// writes and one registered read port (old data on a same-address collision).
module layer_desc_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic [2:0]    wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [95:0]   rd_data
);

  logic [31:0] word0_r [DEPTH];
  logic [31:0] word1_r [DEPTH];
  logic [31:0] word2_r [DEPTH];
  logic [95:0] rd_data_r;

  // Table storage and registered read; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en[0]) word0_r[wr_addr] <= wr_data;
    if (wr_en[1]) word1_r[wr_addr] <= wr_data;
    if (wr_en[2]) word2_r[wr_addr] <= wr_data;
    if (rd_en)    rd_data_r <= {word2_r[rd_addr], word1_r[rd_addr], word0_r[rd_addr]};
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/layer_sequencer.sv
// Autonomous layer scheduler: walks the descriptor table and drives weight,
// bias and compute phases to control_unit, advancing on finish pulses.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 16,
  parameter int LAYER_AW   = 4,
  parameter int TO_WIDTH   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                desc_wr_en,
  input  logic [LAYER_AW-1:0] desc_wr_addr,
  input  logic [1:0]          desc_wr_word,
  input  logic [31:0]         desc_wr_data,
  input  logic [LAYER_AW:0]   num_layers,
  input  logic [TO_WIDTH-1:0] timeout_limit,
  input  logic                start,
  input  logic                abort,
  layer_sequencer_if.master   ctl,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LAYER_AW-1:0] cur_layer,
  output logic [2:0]          state_o
);

  localparam logic [LAYER_AW:0]   LAYER_ONE = {{LAYER_AW{1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0] TO_ONE    = {{(TO_WIDTH-1){1'b0}}, 1'b1};

  seq_state_e          state_r, prev_r;
  logic                busy_r, done_r, error_r;
  logic                skip_w_r, skip_b_r;
  logic [LAYER_AW:0]   layer_r, num_r;
  logic [TO_WIDTH-1:0] to_cnt_r;
  logic [31:0]         ctrl0_r, ctrl1_r, ctrl2_r;

  logic [2:0]          wr_en_s;
  logic                start_ok_s, last_layer_s, adv_layer_s, rd_en_s;
  logic                phase_fin_s, to_hit_s;
  logic [LAYER_AW-1:0] rd_addr_s;
  logic [LAYER_AW:0]   next_layer_s;
  logic [TO_WIDTH-1:0] to_next_s;
  logic [95:0]         rd_data_s;
  seq_state_e          fetch_phase_s, gap_phase_s;

  // Descriptor write decode; the table is frozen while a sequence is running.
  always_comb begin
    wr_en_s = 3'b000;
    if (desc_wr_en && !busy_r) begin
      case (desc_wr_word)
        2'd0:    wr_en_s = 3'b001;
        2'd1:    wr_en_s = 3'b010;
        2'd2:    wr_en_s = 3'b100;
        default: wr_en_s = 3'b000;
      endcase
    end else begin
      wr_en_s = 3'b000;
    end
  end

  // The table read is launched on the edge into FETCH so the words are ready inside FETCH.
  always_comb begin
    start_ok_s   = (state_r == ST_IDLE) && start && !abort && (num_layers != '0);
    next_layer_s = layer_r + LAYER_ONE;
    last_layer_s = (next_layer_s == num_r);
    adv_layer_s  = (state_r == ST_GAP) && (prev_r == ST_RUN) && !last_layer_s && !abort;
    rd_en_s      = start_ok_s || adv_layer_s;
    if (start_ok_s) rd_addr_s = '0;
    else            rd_addr_s = next_layer_s[LAYER_AW-1:0];
  end

  // Phase completion, timeout detection and next-phase selection.
  always_comb begin
    phase_fin_s   = ((state_r == ST_WEIGHT) && ctl.write_weight_finish) ||
                    ((state_r == ST_BIAS)   && ctl.write_bias_finish)   ||
                    ((state_r == ST_RUN)    && ctl.layer_finish);
    to_next_s     = to_cnt_r + TO_ONE;
    to_hit_s      = (timeout_limit != '0) && (to_next_s == timeout_limit);
    fetch_phase_s = next_phase(ST_FETCH, rd_data_s[SKIP_W_BIT], rd_data_s[SKIP_B_BIT]);
    gap_phase_s   = next_phase(prev_r, skip_w_r, skip_b_r);
  end

  layer_desc_ram #(
    .DEPTH (MAX_LAYERS),
    .AW    (LAYER_AW)
  ) u_desc_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (desc_wr_addr),
    .wr_data (desc_wr_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      prev_r   <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      skip_w_r <= 1'b0;
      skip_b_r <= 1'b0;
      layer_r  <= '0;
      num_r    <= '0;
      to_cnt_r <= '0;
      ctrl0_r  <= 32'h0000_0000;
      ctrl1_r  <= 32'h0000_0000;
      ctrl2_r  <= 32'h0000_0000;
    end else if (abort) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ctrl0_r <= with_cmd(ctrl0_r, CMD_IDLE);
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            error_r <= 1'b0;
            if (num_layers == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_FETCH;
              busy_r  <= 1'b1;
              layer_r <= '0;
              num_r   <= num_layers;
            end
          end
        end
        ST_FETCH: begin
          ctrl0_r  <= with_cmd(rd_data_s[31:0], phase_cmd(fetch_phase_s));
          ctrl1_r  <= rd_data_s[63:32];
          ctrl2_r  <= rd_data_s[95:64];
          skip_w_r <= rd_data_s[SKIP_W_BIT];
          skip_b_r <= rd_data_s[SKIP_B_BIT];
          to_cnt_r <= '0;
          state_r  <= fetch_phase_s;
        end
        ST_WEIGHT, ST_BIAS, ST_RUN: begin
          if (phase_fin_s) begin
            state_r <= ST_GAP;
            prev_r  <= state_r;
            ctrl0_r <= with_cmd(ctrl0_r, CMD_IDLE);
          end else if (to_hit_s) begin
            state_r <= ST_ERR;
            error_r <= 1'b1;
            ctrl0_r <= with_cmd(ctrl0_r, CMD_IDLE);
          end else begin
            to_cnt_r <= to_next_s;
          end
        end
        ST_GAP: begin
          if (prev_r != ST_RUN) begin
            state_r  <= gap_phase_s;
            ctrl0_r  <= with_cmd(ctrl0_r, phase_cmd(gap_phase_s));
            to_cnt_r <= '0;
          end else if (last_layer_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
            layer_r <= next_layer_s;
          end
        end
        ST_DONE, ST_ERR: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.axi_control_0 = ctrl0_r;
  assign ctl.axi_control_1 = ctrl1_r;
  assign ctl.axi_control_2 = ctrl2_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign cur_layer = layer_r[LAYER_AW-1:0];
  assign state_o   = state_r;

endmodule
